mul_arbiter: RTL
================

# mul_arbiter

Shares one pipelined 32x32 multiplier among NREQ requesters. Each cycle it picks at most one requester, drives the multiplier's issue port, and tags the in-flight operation with the requester ID. It then returns the 64-bit product on a shared response bus carrying that ID. It sits between the client blocks and the multiplier instance; the multiplier's fixed latency and lack of stall are tracked internally.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- IDW, 2, requester ID width, equals clog2(NREQ)
- LAT, 2, multiplier latency in cycles from vldin to vldout/out

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  grant enable; 0 blocks new grants, in-flight ops still complete
- req_vld  in  NREQ  per-requester request
- req_aa  in  NREQ*32  operand A, requester i at [32*i+:32]
- req_bb  in  NREQ*32  operand B, same packing
- req_gnt  out  NREQ  one-hot (or zero) combinational grant; operands consumed this cycle
- mul_vldin  out  1  registered issue strobe to multiplier
- mul_aa, mul_bb  out  32 each  registered operands to multiplier
- mul_vldout  in  1  multiplier result valid
- mul_out  in  64  multiplier product
- rsp_vld  out  1  registered response valid, single-cycle pulse per op
- rsp_id  out  IDW  requester ID of response
- rsp_data  out  64  product
- issue_cnt  out  32  count of granted ops, wraps at 2^32
- err_sync  out  1  sticky tag/vldout mismatch flag

## Operation
- Handshake: requester holds req_vld and operands stable until it sees req_gnt=1 in the same cycle. The grant cycle completes the transfer. No response backpressure: rsp_vld must be accepted when presented.
- Arbitration (default): round-robin. Pointer ptr starts at 0; the first requesting index at or after ptr wins; after a grant to i, ptr<=i+1 mod NREQ. With no grant, ptr holds.
- Grant requires en=1. Grants issue at up to one per cycle, back-to-back allowed.
- Issue register: on a grant to i, at the clock edge mul_vldin<=1, mul_aa/mul_bb<=req_aa/req_bb[i], and tag stage 0<={1,i}. Otherwise mul_vldin<=0 and operands hold.
- Tag pipe: LAT+1 stages {vld,id}, shifting every cycle. Stage LAT aligns with mul_vldout.
- Response: when stage LAT is valid and mul_vldout=1, then rsp_vld<=1, rsp_id<=stage id, rsp_data<=mul_out.
- Mismatch: if stage LAT valid differs from mul_vldout, err_sync<=1 and no response is produced. err_sync clears only on reset.
- Reset values: req_gnt 0, mul_vldin 0, mul_aa/mul_bb 0, rsp_vld 0, rsp_id 0, rsp_data 0, issue_cnt 0, err_sync 0, ptr 0, all tag stages invalid.
- Reset mid-operation drops all in-flight tags. The multiplier's own valid pipe resets together with it, so no response appears after release and err_sync stays 0.

## Timing
- Grant in cycle t; mul_vldin high in t+1; mul_vldout in t+1+LAT; rsp_vld in t+2+LAT (t+4 for LAT=2).
- Throughput is 1 op/cycle. Responses return in grant order.
- req_gnt is combinational from req_vld, en and ptr only; it has no path from operands.

## Configuration
- MUL_ARB_FIXED_PRIO_EN defined: fixed priority, lowest requesting index wins, and the ptr register is removed.
- Undefined: round-robin as described.
- All other behaviour is identical in both modes.

## Structure
- Package mul_arb_pkg holds:
  - MUL_W=32, PROD_W=64, MUL_LAT=2
  - typedef mul_tag_t {vld, id}
- Sub-module rr_arbiter: NREQ-wide request vector plus en in; one-hot grant and pointer state out. It holds the MUL_ARB_FIXED_PRIO_EN switch.
- mul_arbiter holds the issue register, tag pipe, response register and counters. The multiplier is instantiated outside.

## Test plan
- Req0 only, aa=3, bb=5, grant at t -> rsp_vld at t+4, rsp_id=0, rsp_data=15, issue_cnt=1.
- Req2, aa=bb=0xFFFFFFFF -> rsp_data=0xFFFFFFFE00000001, rsp_id=2.
- All four requesting for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; 8 back-to-back responses with ids in the same order; issue_cnt=8.
- Requests held with en=0 for 5 cycles -> req_gnt=0, no issue. en=1 after a prior grant to 1 -> next grant goes to 2.
- rst_n asserted with 2 ops in flight, released 3 cycles later -> rsp_vld never pulses, err_sync=0, issue_cnt=0.
- mul_vldout forced high with no op issued -> err_sync=1 and stays high, rsp_vld=0. With MUL_ARB_FIXED_PRIO_EN, req0 and req3 continuous -> every grant goes to 0.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// ============================================================================
// Module      : mul_arb_pkg
// Description : Shared widths, latency and tag type for the multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_arb_pkg;

    localparam int MUL_W    = 32;
    localparam int PROD_W   = 64;
    localparam int MUL_LAT  = 2;
    // Wide enough for the largest supported requester count (16).
    localparam int TAG_ID_W = 4;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : One-of-NREQ grant selector; round-robin by default, fixed
//               lowest-index priority when MUL_ARB_FIXED_PRIO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_gnt_vld,
    output logic [IDW-1:0]  o_gnt_id
);

`ifdef MUL_ARB_FIXED_PRIO_EN

    // Scan from the top down so the lowest requesting index is written last.
    always_comb begin
        o_gnt     = '0;
        o_gnt_vld = 1'b0;
        o_gnt_id  = '0;
        if (i_en) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (i_req[i]) begin
                    o_gnt_vld = 1'b1;
                    o_gnt_id  = IDW'(i);
                end
            end
        end
        if (o_gnt_vld) begin
            o_gnt[o_gnt_id] = 1'b1;
        end
    end

`else

    logic [IDW-1:0] r_ptr;

    // Walk the ring backwards from ptr+NREQ-1 down to ptr; the last hit is
    // the first requester at or after ptr.
    always_comb begin
        int w_idx;
        o_gnt     = '0;
        o_gnt_vld = 1'b0;
        o_gnt_id  = '0;
        w_idx     = 0;
        if (i_en) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= NREQ) begin
                    w_idx = w_idx - NREQ;
                end
                if (i_req[w_idx]) begin
                    o_gnt_vld = 1'b1;
                    o_gnt_id  = IDW'(w_idx);
                end
            end
        end
        if (o_gnt_vld) begin
            o_gnt[o_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_gnt_vld) begin
            r_ptr <= (o_gnt_id == IDW'(NREQ - 1)) ? '0 : o_gnt_id + 1'b1;
        end
    end

`endif

endmodule

`default_nettype wire

// File: rtl/mul_arbiter.sv
// ============================================================================
// Module      : mul_arbiter
// Description : Shares one fixed-latency pipelined multiplier among NREQ
//               requesters and routes each product back with its requester ID.
//               Define MUL_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = MUL_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ*MUL_W-1:0] req_aa,
    input  logic [NREQ*MUL_W-1:0] req_bb,
    output logic [NREQ-1:0]       req_gnt,
    output logic                  mul_vldin,
    output logic [MUL_W-1:0]      mul_aa,
    output logic [MUL_W-1:0]      mul_bb,
    input  logic                  mul_vldout,
    input  logic [PROD_W-1:0]     mul_out,
    output logic                  rsp_vld,
    output logic [IDW-1:0]        rsp_id,
    output logic [PROD_W-1:0]     rsp_data,
    output logic [31:0]           issue_cnt,
    output logic                  err_sync
);

    logic              w_gnt_vld;
    logic [IDW-1:0]    w_gnt_id;
    logic [MUL_W-1:0]  w_sel_aa;
    logic [MUL_W-1:0]  w_sel_bb;
    mul_tag_t          w_tail;

    logic              r_mul_vldin;
    logic [MUL_W-1:0]  r_mul_aa;
    logic [MUL_W-1:0]  r_mul_bb;
    mul_tag_t          r_tag [0:LAT];
    logic              r_rsp_vld;
    logic [IDW-1:0]    r_rsp_id;
    logic [PROD_W-1:0] r_rsp_data;
    logic [31:0]       r_issue_cnt;
    logic              r_err_sync;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (en),
        .i_req     (req_vld),
        .o_gnt     (req_gnt),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    assign w_sel_aa = req_aa[w_gnt_id*MUL_W +: MUL_W];
    assign w_sel_bb = req_bb[w_gnt_id*MUL_W +: MUL_W];
    assign w_tail   = r_tag[LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_vldin <= 1'b0;
            r_mul_aa    <= '0;
            r_mul_bb    <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_mul_vldin <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_mul_aa    <= w_sel_aa;
                r_mul_bb    <= w_sel_bb;
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
        end
    end

    // Tag pipe mirrors the multiplier's valid pipe; stage LAT lines up with mul_vldout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: w_gnt_vld, id: TAG_ID_W'(w_gnt_id)};
            for (int s = 1; s <= LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
            r_err_sync <= 1'b0;
        end else begin
            r_rsp_vld <= w_tail.vld & mul_vldout;
            if (w_tail.vld & mul_vldout) begin
                r_rsp_id   <= IDW'(w_tail.id);
                r_rsp_data <= mul_out;
            end
            if (w_tail.vld != mul_vldout) begin
                r_err_sync <= 1'b1;
            end
        end
    end

    assign mul_vldin = r_mul_vldin;
    assign mul_aa    = r_mul_aa;
    assign mul_bb    = r_mul_bb;
    assign rsp_vld   = r_rsp_vld;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign issue_cnt = r_issue_cnt;
    assign err_sync  = r_err_sync;

endmodule

`default_nettype wire
